// File: rtl/oled_spi_tx.sv
// oled_spi_tx: FIFO-fed SPI (mode 3) serializer for an SSD1306-class OLED.
// Words {DC, byte} are queued in a small FIFO. Each byte is shifted MSB first
// with a programmable SCLK half-period. Chip select stays low across
// back-to-back bytes.
module oled_spi_tx #(
    parameter int DIV     = 4,
    parameter int FIFO_AW = 3
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic [8:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [FIFO_AW:0] fifo_level,
    output logic             busy,
    output logic             OLED_SCLK,
    output logic             OLED_SDIN,
    output logic             OLED_DC,
    output logic             OLED_CS_N
);

    localparam int                 DEPTH    = 2 ** FIFO_AW;
    localparam int                 CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]      CNT_MAX  = CW'(DIV - 1);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOW,
        S_HIGH,
        S_HOLD
    } state_t;

    // FIFO storage and bookkeeping
    logic [8:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic [8:0]         head;

    // Serializer state
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic          sclk_q, sclk_d;
    logic          dc_q, dc_d;
    logic          csn_q, csn_d;
    logic          tick;
    logic          load;

    assign tx_ready   = (level_q != LVL_FULL);
    assign fifo_level = level_q;
    assign fifo_empty = (level_q == '0);
    assign push       = tx_valid & tx_ready;
    assign head       = mem_q[rd_ptr_q];
    assign busy       = (state_q != S_IDLE) || !fifo_empty;

    // The shift register's MSB is the data line; it is held at all-ones while idle.
    assign OLED_SDIN  = shreg_q[7];
    assign OLED_SCLK  = sclk_q;
    assign OLED_DC    = dc_q;
    assign OLED_CS_N  = csn_q;

    // FIFO payload write; storage needs no reset since level gates every read.
    always_ff @(posedge HCLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    // FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // FIFO pointer and occupancy registers.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign tick = (cnt_q == CNT_MAX);

    // Serializer next-state: divider, FSM transitions and line updates.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        sclk_d   = sclk_q;
        dc_d     = dc_q;
        csn_d    = csn_q;
        pop      = 1'b0;
        load     = 1'b0;
        cnt_d    = (state_q == S_IDLE || tick) ? '0 : cnt_q + CNT_ONE;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    load    = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (tick) begin
                    sclk_d  = 1'b0;
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (tick) begin
                    if (bitcnt_q != 3'd0) begin
                        sclk_d   = 1'b0;
                        shreg_d  = {shreg_q[6:0], 1'b1};
                        bitcnt_d = bitcnt_q - 3'd1;
                        state_d  = S_LOW;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (tick) begin
                    if (!fifo_empty) begin
                        load    = 1'b1;
                        state_d = S_SETUP;
                    end else begin
                        csn_d   = 1'b1;
                        shreg_d = 8'hFF;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A load pops the head word and presents its MSB and D/C at once.
        if (load) begin
            pop      = 1'b1;
            shreg_d  = head[7:0];
            dc_d     = head[8];
            csn_d    = 1'b0;
            bitcnt_d = 3'd7;
        end
    end

    // Serializer registers; every output returns to idle levels on reset.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shreg_q  <= 8'hFF;
            bitcnt_q <= 3'd0;
            sclk_q   <= 1'b1;
            dc_q     <= 1'b0;
            csn_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            sclk_q   <= sclk_d;
            dc_q     <= dc_d;
            csn_q    <= csn_d;
        end
    end

endmodule

// File: tb/tb_oled_spi_tx.sv
// Bench for oled_spi_tx: three instances (DIV = 2, 4, 1) share clock and reset.
// Accepted words are queued as expected bytes; a monitor decodes the SPI lines
// and checks framing and timing from the per-byte rules.
module tb_oled_spi_tx;

    localparam int NI = 3;
    localparam int DIVS [NI] = '{2, 4, 1};

    logic       HCLK = 1'b0;
    logic       HRESET = 1'b1;
    logic [8:0] tx_data  [NI];
    logic       tx_valid [NI];
    logic       tx_ready [NI];
    logic [3:0] fifo_level [NI];
    logic       busy [NI];
    logic       sclk [NI];
    logic       sdin [NI];
    logic       dc   [NI];
    logic       csn  [NI];

    always #5 HCLK = ~HCLK;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        oled_spi_tx #(.DIV(DIVS[g]), .FIFO_AW(3)) u_dut (
            .HCLK       (HCLK),
            .HRESET     (HRESET),
            .tx_data    (tx_data[g]),
            .tx_valid   (tx_valid[g]),
            .tx_ready   (tx_ready[g]),
            .fifo_level (fifo_level[g]),
            .busy       (busy[g]),
            .OLED_SCLK  (sclk[g]),
            .OLED_SDIN  (sdin[g]),
            .OLED_DC    (dc[g]),
            .OLED_CS_N  (csn[g])
        );
    end

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q [NI][$];

    // monitor state
    int         mon_bits   [NI];
    int         low_run    [NI];
    int         burst_cnt  [NI];
    int         bytes_done [NI];
    int         last_rise  [NI];
    int         byte_end   [NI];
    int         last_burst_bytes [NI];
    int         last_burst_len   [NI];
    logic [7:0] acc     [NI];
    logic       byte_dc [NI];
    logic       p_sclk [NI];
    logic       p_sdin [NI];
    logic       p_dc   [NI];
    logic       p_csn  [NI];

    task automatic check(input string name, input int inst, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[inst %0d]: got 0x%0h, want 0x%0h", name, inst, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge HCLK);
            for (int i = 0; i < NI; i++) begin
                if (HRESET) begin
                    mon_bits[i]  = 0;
                    low_run[i]   = 0;
                    burst_cnt[i] = 0;
                end else begin
                    if (!csn[i]) low_run[i]++;
                    if (!p_sclk[i] && sclk[i]) begin
                        check("rise_inside_cs", i, int'(csn[i]), 0);
                        check("sdin_stable_at_rise", i, int'(sdin[i]), int'(p_sdin[i]));
                        check("dc_stable_at_rise", i, int'(dc[i]), int'(p_dc[i]));
                        check("busy_in_byte", i, int'(busy[i]), 1);
                        if (mon_bits[i] == 0) begin
                            byte_dc[i] = dc[i];
                        end else begin
                            check("rise_spacing", i, low_run[i] - last_rise[i], 2 * DIVS[i]);
                            check("dc_within_byte", i, int'(dc[i]), int'(byte_dc[i]));
                        end
                        last_rise[i] = low_run[i];
                        acc[i] = {acc[i][6:0], sdin[i]};
                        mon_bits[i]++;
                        if (mon_bits[i] == 8) begin
                            mon_bits[i] = 0;
                            burst_cnt[i]++;
                            bytes_done[i]++;
                            byte_end[i] = low_run[i];
                            if (exp_q[i].size() == 0)
                                check("byte_unexpected", i, int'({byte_dc[i], acc[i]}), 32'h1000);
                            else
                                check("byte", i, int'({byte_dc[i], acc[i]}), int'(exp_q[i].pop_front()));
                        end
                    end
                    if (!csn[i] && !p_csn[i] && dc[i] != p_dc[i]) begin
                        check("dc_change_bitpos", i, mon_bits[i], 0);
                        check("dc_change_time", i, low_run[i] - byte_end[i], 2 * DIVS[i]);
                    end
                    if (!p_csn[i] && csn[i]) begin
                        check("cs_low_len", i, low_run[i], 18 * DIVS[i] * burst_cnt[i]);
                        check("bits_at_cs_rise", i, mon_bits[i], 0);
                        check("sclk_idle", i, int'(sclk[i]), 1);
                        check("sdin_idle", i, int'(sdin[i]), 1);
                        check("busy_at_cs_rise", i, int'(busy[i]), int'(fifo_level[i] != 4'd0));
                        last_burst_bytes[i] = burst_cnt[i];
                        last_burst_len[i]   = low_run[i];
                        low_run[i]   = 0;
                        burst_cnt[i] = 0;
                    end
                end
                p_sclk[i] = sclk[i];
                p_sdin[i] = sdin[i];
                p_dc[i]   = dc[i];
                p_csn[i]  = csn[i];
            end
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic push(input int i, input logic [8:0] w);
        int   n = 0;
        logic ok;
        tx_valid[i] = 1'b1;
        tx_data[i]  = w;
        do begin
            ok = tx_ready[i];
            step();
            n++;
        end while (!ok && n < 1000);
        if (ok) exp_q[i].push_back(w);
        else check("push_timeout", i, int'(ok), 1);
    endtask

    task automatic wait_idle(input int i, input int budget);
        int n = 0;
        tx_valid[i] = 1'b0;
        while (busy[i] && n < budget) begin
            step();
            n++;
        end
        check("idle_timeout", i, int'(busy[i]), 0);
        step();
        step();
        check("queue_drained", i, exp_q[i].size(), 0);
    endtask

    initial begin
        int         acc_cnt;
        int         done0;
        int         n;
        logic       ok;
        logic       quiet;
        logic [8:0] w;

        for (int i = 0; i < NI; i++) begin
            tx_valid[i] = 1'b0;
            tx_data[i]  = 9'h0;
            mon_bits[i] = 0; low_run[i] = 0; burst_cnt[i] = 0; bytes_done[i] = 0;
            last_rise[i] = 0; byte_end[i] = 0; last_burst_bytes[i] = 0; last_burst_len[i] = 0;
            acc[i] = 8'h0; byte_dc[i] = 1'b0;
            p_sclk[i] = 1'b1; p_sdin[i] = 1'b1; p_dc[i] = 1'b0; p_csn[i] = 1'b1;
        end
        fork
            monitor();
        join_none

        repeat (3) step();
        for (int i = 0; i < NI; i++) begin
            check("rst_sclk", i, int'(sclk[i]), 1);
            check("rst_sdin", i, int'(sdin[i]), 1);
            check("rst_dc", i, int'(dc[i]), 0);
            check("rst_csn", i, int'(csn[i]), 1);
            check("rst_level", i, int'(fifo_level[i]), 0);
            check("rst_ready", i, int'(tx_ready[i]), 1);
            check("rst_busy", i, int'(busy[i]), 0);
        end
        HRESET = 1'b0;
        step();

        // single command byte, DIV=2
        push(0, 9'h0A5);
        tx_valid[0] = 1'b0;
        check("csn_cycle_after_push", 0, int'(csn[0]), 1);
        check("level_after_push", 0, int'(fifo_level[0]), 1);
        check("busy_after_push", 0, int'(busy[0]), 1);
        step();
        check("csn_at_load", 0, int'(csn[0]), 0);
        check("dc_at_load", 0, int'(dc[0]), 0);
        check("sdin_msb_at_load", 0, int'(sdin[0]), 1);
        check("level_after_pop", 0, int'(fifo_level[0]), 0);
        wait_idle(0, 500);
        check("single_burst_len", 0, last_burst_len[0], 36);

        // three data bytes back to back, DIV=2
        push(0, 9'h1FF);
        push(0, 9'h000);
        push(0, 9'h13C);
        wait_idle(0, 1000);
        check("triple_burst_bytes", 0, last_burst_bytes[0], 3);
        check("triple_burst_len", 0, last_burst_len[0], 108);

        // command then data: DC must flip only at the second load
        push(0, 9'h0AE);
        push(0, 9'h155);
        wait_idle(0, 1000);
        check("mixed_burst_bytes", 0, last_burst_bytes[0], 2);

        // DIV=1 single byte
        push(2, 9'h081);
        wait_idle(2, 200);
        check("div1_burst_len", 2, last_burst_len[2], 18);

        // fill the FIFO with tx_valid held for 10 cycles, DIV=4
        acc_cnt = 0;
        done0   = bytes_done[1];
        tx_valid[1] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            w = 9'($urandom);
            tx_data[1] = w;
            ok = tx_ready[1];
            if (c == 9) begin
                check("full_ready", 1, int'(tx_ready[1]), 0);
                check("full_level", 1, int'(fifo_level[1]), 8);
            end
            step();
            if (ok) begin
                acc_cnt++;
                exp_q[1].push_back(w);
            end
        end
        tx_valid[1] = 1'b0;
        check("accepted_words", 1, acc_cnt, 9);
        n = 0;
        while (!tx_ready[1] && n < 400) begin
            step();
            n++;
        end
        check("ready_returns", 1, int'(tx_ready[1]), 1);
        check("level_at_ready_return", 1, int'(fifo_level[1]), 7);
        check("bytes_before_ready_return", 1, bytes_done[1] - done0, 1);
        wait_idle(1, 2000);

        // reset during the 4th LOW phase with 3 words still queued
        for (int k = 0; k < 4; k++) push(1, 9'($urandom));
        tx_valid[1] = 1'b0;
        n = 0;
        while (!(mon_bits[1] == 3 && sclk[1] == 1'b0) && n < 400) begin
            step();
            n++;
        end
        check("reach_4th_low", 1, int'(mon_bits[1] == 3 && sclk[1] == 1'b0), 1);
        check("queued_before_reset", 1, int'(fifo_level[1]), 3);
        HRESET = 1'b1;
        #1;
        check("midrst_sclk", 1, int'(sclk[1]), 1);
        check("midrst_sdin", 1, int'(sdin[1]), 1);
        check("midrst_csn", 1, int'(csn[1]), 1);
        check("midrst_dc", 1, int'(dc[1]), 0);
        check("midrst_level", 1, int'(fifo_level[1]), 0);
        check("midrst_ready", 1, int'(tx_ready[1]), 1);
        exp_q[1].delete();
        step();
        HRESET = 1'b0;
        quiet = 1'b1;
        for (int c = 0; c < 100; c++) begin
            step();
            if (!sclk[1] || !csn[1] || busy[1]) quiet = 1'b0;
        end
        check("quiet_after_reset", 1, int'(quiet), 1);

        // randomized traffic on every instance
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NI; i++) begin
                n = int'($urandom_range(3, 12));
                for (int k = 0; k < n; k++) begin
                    push(i, 9'($urandom));
                    tx_valid[i] = 1'b0;
                    repeat ($urandom_range(0, 3) * (($urandom_range(0, 3) == 0) ? 15 : 1)) step();
                end
                wait_idle(i, 4000);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
